// File: rtl/key_event_uart_reporter.sv
// key_event_uart_reporter
// Debounces N_KEYS raw buttons and turns press events (and, with
// RELEASE_EVT_EN defined, release events) into tagged bytes. The bytes are
// queued in a small FIFO and sent on an 8N1 UART TX line.
// Event byte: bit7 = press(1)/release(0), bits6:4 = event count before
// increment, bits3:0 = key index.
// Optional feature macro: RELEASE_EVT_EN (undefined: presses only).
module key_event_uart_reporter #(
    parameter int N_KEYS     = 2,
    parameter int ACTIVE_LOW = 1,
    parameter int DEB_CYCLES = 540000,
    parameter int COUNT_W    = 2,
    parameter int FIFO_DEPTH = 8,
    parameter int CLK_HZ     = 27000000,
    parameter int BAUD       = 115200
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_KEYS-1:0]  key_in,
    output logic [N_KEYS-1:0]  key_level,
    output logic [COUNT_W-1:0] count,
    output logic               uart_tx,
    output logic               busy,
    output logic               fifo_full,
    output logic               overflow
);

    localparam int BIT_CYCLES = CLK_HZ / BAUD;
    localparam int DEB_W      = $clog2(DEB_CYCLES);
    localparam int BIT_W      = $clog2(BIT_CYCLES);
    localparam int PTR_W      = $clog2(FIFO_DEPTH);

    localparam logic [DEB_W-1:0]  DEB_MAX  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [BIT_W-1:0]  BIT_MAX  = BIT_W'(BIT_CYCLES - 1);
    localparam logic [PTR_W:0]    OCC_FULL = (PTR_W + 1)'(FIFO_DEPTH);
    // Synchroniser reset value is the raw "released" level, so a key held
    // through reset is seen as a fresh press once reset is released.
    localparam logic [N_KEYS-1:0] RAW_IDLE = (ACTIVE_LOW != 0) ? {N_KEYS{1'b1}} : {N_KEYS{1'b0}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } uart_state_t;

    // ------------------------------------------------------------------
    // Input synchronisation and debounce
    // ------------------------------------------------------------------
    logic [N_KEYS-1:0] sync_q1;
    logic [N_KEYS-1:0] sync_q2;
    logic [N_KEYS-1:0] key_sync;
    logic [DEB_W-1:0]  deb_cnt [N_KEYS];
    logic [N_KEYS-1:0] deb_accept;
    logic [N_KEYS-1:0] press_edge;

    // Two-flop synchroniser per key
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1 <= RAW_IDLE;
            sync_q2 <= RAW_IDLE;
        end else begin
            sync_q1 <= key_in;
            sync_q2 <= sync_q1;
        end
    end

    // Polarity normalisation and debounce acceptance (1 = pressed)
    always_comb begin
        deb_accept = '0;
        key_sync   = (ACTIVE_LOW != 0) ? ~sync_q2 : sync_q2;
        for (int unsigned i = 0; i < N_KEYS; i++) begin
            deb_accept[i] = (key_sync[i] != key_level[i]) && (deb_cnt[i] == DEB_MAX);
        end
        press_edge = deb_accept & key_sync;
    end

    // Debounce counters and accepted key level
    always_ff @(posedge clk) begin
        if (rst) begin
            key_level <= '0;
            for (int unsigned i = 0; i < N_KEYS; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N_KEYS; i++) begin
                if ((key_sync[i] == key_level[i]) || deb_accept[i]) begin
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
            key_level <= key_level ^ deb_accept;
        end
    end

    // ------------------------------------------------------------------
    // Pending event flags and arbiter
    // ------------------------------------------------------------------
    logic [N_KEYS-1:0] pend_press;
    logic [N_KEYS-1:0] serve_press;
    logic              ev_valid;
    logic              ev_press;
    logic [3:0]        ev_key;
    logic [2:0]        cnt_tag;
    logic [7:0]        ev_byte;

`ifdef RELEASE_EVT_EN
    logic [N_KEYS-1:0] pend_release;
    logic [N_KEYS-1:0] serve_release;
    logic [N_KEYS-1:0] release_edge;

    // Release edges, only present when release events are enabled
    always_comb begin
        release_edge = deb_accept & ~key_sync;
    end

    // Pending release flags: served flag clears, a new edge sets/merges
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_release <= '0;
        end else begin
            pend_release <= (pend_release & ~serve_release) | release_edge;
        end
    end
`endif

    // Pending press flags: served flag clears, a new edge sets/merges
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_press <= '0;
        end else begin
            pend_press <= (pend_press & ~serve_press) | press_edge;
        end
    end

    // Lowest-index pending event wins; press beats release on the same key
    always_comb begin
        ev_valid    = 1'b0;
        ev_press    = 1'b1;
        ev_key      = '0;
        serve_press = '0;
`ifdef RELEASE_EVT_EN
        serve_release = '0;
`endif
        for (int unsigned i = 0; i < N_KEYS; i++) begin
            if (!ev_valid) begin
                if (pend_press[i]) begin
                    ev_valid       = 1'b1;
                    ev_press       = 1'b1;
                    ev_key         = 4'(i);
                    serve_press[i] = 1'b1;
                end
`ifdef RELEASE_EVT_EN
                else if (pend_release[i]) begin
                    ev_valid         = 1'b1;
                    ev_press         = 1'b0;
                    ev_key           = 4'(i);
                    serve_release[i] = 1'b1;
                end
`endif
            end
        end
    end

    if (COUNT_W >= 3) begin : g_tag_trunc
        assign cnt_tag = count[2:0];
    end else begin : g_tag_ext
        assign cnt_tag = 3'(count);
    end

    assign ev_byte = {ev_press, cnt_tag, ev_key};

    // ------------------------------------------------------------------
    // Event FIFO
    // ------------------------------------------------------------------
    uart_state_t      state;
    uart_state_t      state_nxt;
    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   fifo_occ;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             drop;

    // FIFO status and push/pop/drop decisions; a pop frees the slot a
    // same-cycle push needs, so a full FIFO still accepts in that case
    always_comb begin
        fifo_empty = (fifo_occ == '0);
        fifo_full  = (fifo_occ == OCC_FULL);
        pop        = (state == S_IDLE) && !fifo_empty;
        push       = ev_valid && (!fifo_full || pop);
        drop       = ev_valid && !push;
    end

    // FIFO storage write port
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= ev_byte;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_occ <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_occ <= fifo_occ + 1'b1;
                2'b01:   fifo_occ <= fifo_occ - 1'b1;
                default: fifo_occ <= fifo_occ;
            endcase
        end
    end

    // Event counter and sticky overflow flag
    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                count <= count + 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // UART transmitter
    // ------------------------------------------------------------------
    logic [BIT_W-1:0] bit_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             bit_tick;

    // UART state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // UART next-state logic
    always_comb begin
        state_nxt = state;
        bit_tick  = (bit_cnt == BIT_MAX);
        case (state)
            S_IDLE:  if (!fifo_empty) state_nxt = S_START;
            S_START: if (bit_tick) state_nxt = S_DATA;
            S_DATA:  if (bit_tick && (bit_idx == 3'd7)) state_nxt = S_STOP;
            S_STOP:  if (bit_tick) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // UART outputs
    always_comb begin
        case (state)
            S_START: uart_tx = 1'b0;
            S_DATA:  uart_tx = shreg[0];
            default: uart_tx = 1'b1;
        endcase
        busy = (state != S_IDLE) || !fifo_empty;
    end

    // Bit timer, bit index and shift register
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            if ((state == S_IDLE) || bit_tick) begin
                bit_cnt <= '0;
            end else begin
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (pop) begin
                shreg <= fifo_mem[rd_ptr];
            end else if ((state == S_DATA) && bit_tick) begin
                shreg <= {1'b0, shreg[7:1]};
            end
            if (state != S_DATA) begin
                bit_idx <= '0;
            end else if (bit_tick) begin
                bit_idx <= bit_idx + 1'b1;
            end
        end
    end

endmodule
